// File: rtl/ttt_move_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ttt_move_ctrl_pkg                                     |
// | Brief    : Shared types and constants for the TicTacToe move     |
// |            controller (board size, symbols, FSM states, lines).  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package ttt_move_ctrl_pkg;

  // Board geometry
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  // Symbol encoding shared with the board cells
  localparam logic SYM_X = 1'b0;
  localparam logic SYM_O = 1'b1;

  // Highest legal cell index, last line number, move count one short of a full board
  localparam logic [3:0] LAST_CELL     = 4'(NUM_CELLS - 1);
  localparam logic [2:0] LAST_LINE     = 3'(NUM_LINES - 1);
  localparam logic [3:0] LAST_MOVE_CNT = 4'(NUM_CELLS - 1);

  // Controller states
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_READY = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The three cell indices forming one winning line
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } line_t;

endpackage
`default_nettype wire

// File: rtl/ttt_move_ctrl_line_lut.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ttt_move_ctrl_line_lut                                |
// | Brief    : Combinational table mapping a line number (0..7) to   |
// |            its three row-major cell indices: rows 0-2, columns   |
// |            3-5, main diagonal 6, anti-diagonal 7.                |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module ttt_move_ctrl_line_lut
  import ttt_move_ctrl_pkg::*;
(
  input  logic [2:0] line_sel,
  output line_t      cells
);

  // Constant line table; every 3-bit code is a real line so no fallback is needed
  always_comb begin
    case (line_sel)
      3'd0: cells = '{a: 4'd0, b: 4'd1, c: 4'd2};
      3'd1: cells = '{a: 4'd3, b: 4'd4, c: 4'd5};
      3'd2: cells = '{a: 4'd6, b: 4'd7, c: 4'd8};
      3'd3: cells = '{a: 4'd0, b: 4'd3, c: 4'd6};
      3'd4: cells = '{a: 4'd1, b: 4'd4, c: 4'd7};
      3'd5: cells = '{a: 4'd2, b: 4'd5, c: 4'd8};
      3'd6: cells = '{a: 4'd0, b: 4'd4, c: 4'd8};
      3'd7: cells = '{a: 4'd2, b: 4'd4, c: 4'd6};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ttt_move_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ttt_move_ctrl                                         |
// | Brief    : TicTacToe game controller. Accepts moves over a       |
// |            valid/ready handshake, writes the nine board cells,   |
// |            alternates turns, rejects illegal moves and scans the |
// |            eight lines one per cycle for a win or a draw.        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module ttt_move_ctrl
  import ttt_move_ctrl_pkg::*;
#(
  parameter logic FIRST_SYMBOL = SYM_X,  // symbol of the first mover
  parameter logic ALT_START    = 1'b0    // 1: first mover alternates per new_game
) (
  input  logic                 clk,
  input  logic                 reset,           // asynchronous, active-low
  input  logic                 new_game,
  input  logic                 move_valid,
  output logic                 move_ready,
  input  logic [3:0]           move_idx,
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  output logic [NUM_CELLS-1:0] cell_set,
  output logic                 cell_set_symbol,
  output logic                 cell_reset,
  output logic                 turn,
  output logic                 move_ack,
  output logic                 move_err,
  output logic                 game_over,
  output logic                 winner_valid,
  output logic                 winner,
  output logic                 draw,
  output logic [3:0]           move_count
);

  // ---------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------
  state_t               state_q,           state_d;
  logic [2:0]           line_q,            line_d;
  logic                 turn_q,            turn_d;
  logic                 start_sym_q,       start_sym_d;
  logic                 new_game_prev_q;
  logic                 move_ready_q,      move_ready_d;
  logic [NUM_CELLS-1:0] cell_set_q,        cell_set_d;
  logic                 cell_set_symbol_q, cell_set_symbol_d;
  logic                 cell_reset_q,      cell_reset_d;
  logic                 move_ack_q,        move_ack_d;
  logic                 move_err_q,        move_err_d;
  logic                 game_over_q,       game_over_d;
  logic                 winner_valid_q,    winner_valid_d;
  logic                 winner_q,          winner_d;
  logic                 draw_q,            draw_d;
  logic [3:0]           move_count_q,      move_count_d;

  // ---------------------------------------------------------------
  // Line lookup and per-cycle decode
  // ---------------------------------------------------------------
  line_t line_cells;
  logic  line_win;
  logic  accept;
  logic  move_illegal;
  logic  new_game_rise;

  ttt_move_ctrl_line_lut u_line_lut (
    .line_sel (line_q),
    .cells    (line_cells)
  );

  // Current line wins when all three cells hold the symbol of the player who just moved
  always_comb begin
    line_win = cell_valid[line_cells.a] & cell_valid[line_cells.b] & cell_valid[line_cells.c] &
               (cell_symbol[line_cells.a] == turn_q) &
               (cell_symbol[line_cells.b] == turn_q) &
               (cell_symbol[line_cells.c] == turn_q);
  end

  // Handshake qualification; new_game blocks acceptance in the same cycle
  always_comb begin
    accept        = move_valid & move_ready_q & ~new_game;
    move_illegal  = (move_idx > LAST_CELL) || cell_valid[move_idx];
    new_game_rise = new_game & ~new_game_prev_q;
  end

  // Next-state and next-output logic for the game FSM
  always_comb begin
    state_d           = state_q;
    line_d            = line_q;
    turn_d            = turn_q;
    move_ready_d      = move_ready_q;
    cell_set_d        = '0;
    cell_set_symbol_d = 1'b0;
    cell_reset_d      = 1'b0;
    move_ack_d        = 1'b0;
    move_err_d        = 1'b0;
    game_over_d       = game_over_q;
    winner_valid_d    = winner_valid_q;
    winner_d          = winner_q;
    draw_d            = draw_q;
    move_count_d      = move_count_q;

    // Start symbol flips once per new_game request, not once per held cycle
    start_sym_d = (ALT_START && new_game_rise) ? ~start_sym_q : start_sym_q;

    if (new_game) begin
      // Abort whatever is in flight; CLEAR wipes any cell already committed
      state_d        = ST_CLEAR;
      cell_reset_d   = 1'b1;
      move_ready_d   = 1'b0;
      line_d         = '0;
      turn_d         = start_sym_d;
      game_over_d    = 1'b0;
      winner_valid_d = 1'b0;
      winner_d       = 1'b0;
      draw_d         = 1'b0;
      move_count_d   = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          state_d        = ST_READY;
          move_ready_d   = 1'b1;
          line_d         = '0;
          turn_d         = start_sym_q;
          game_over_d    = 1'b0;
          winner_valid_d = 1'b0;
          winner_d       = 1'b0;
          draw_d         = 1'b0;
          move_count_d   = '0;
        end

        ST_READY: begin
          if (accept) begin
            if (move_illegal) begin
              move_err_d = 1'b1;
            end else begin
              // Strobe lands in the WRITE cycle as a registered one-hot
              state_d           = ST_WRITE;
              move_ready_d      = 1'b0;
              cell_set_d        = NUM_CELLS'(1) << move_idx;
              cell_set_symbol_d = turn_q;
            end
          end
        end

        ST_WRITE: begin
          // Cells capture the write at the end of this cycle; scanning starts next
          state_d = ST_CHECK;
          line_d  = '0;
        end

        ST_CHECK: begin
          if (line_win) begin
            state_d        = ST_DONE;
            move_ready_d   = 1'b1;
            game_over_d    = 1'b1;
            winner_valid_d = 1'b1;
            winner_d       = turn_q;
            move_count_d   = move_count_q + 4'd1;
          end else if (line_q == LAST_LINE) begin
            move_count_d = move_count_q + 4'd1;
            move_ready_d = 1'b1;
            if (move_count_q == LAST_MOVE_CNT) begin
              state_d     = ST_DONE;
              game_over_d = 1'b1;
              draw_d      = 1'b1;
            end else begin
              state_d    = ST_READY;
              turn_d     = ~turn_q;
              move_ack_d = 1'b1;
            end
          end else begin
            line_d = line_q + 3'd1;
          end
        end

        ST_DONE: begin
          // Keep draining moves so the source never stalls; all are rejected
          if (accept) begin
            move_err_d = 1'b1;
          end
        end

        default: begin
          state_d      = ST_CLEAR;
          cell_reset_d = 1'b1;
          move_ready_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_CLEAR;
      line_q            <= '0;
      turn_q            <= FIRST_SYMBOL;
      start_sym_q       <= FIRST_SYMBOL;
      new_game_prev_q   <= 1'b0;
      move_ready_q      <= 1'b0;
      cell_set_q        <= '0;
      cell_set_symbol_q <= 1'b0;
      cell_reset_q      <= 1'b1;
      move_ack_q        <= 1'b0;
      move_err_q        <= 1'b0;
      game_over_q       <= 1'b0;
      winner_valid_q    <= 1'b0;
      winner_q          <= 1'b0;
      draw_q            <= 1'b0;
      move_count_q      <= '0;
    end else begin
      state_q           <= state_d;
      line_q            <= line_d;
      turn_q            <= turn_d;
      start_sym_q       <= start_sym_d;
      new_game_prev_q   <= new_game;
      move_ready_q      <= move_ready_d;
      cell_set_q        <= cell_set_d;
      cell_set_symbol_q <= cell_set_symbol_d;
      cell_reset_q      <= cell_reset_d;
      move_ack_q        <= move_ack_d;
      move_err_q        <= move_err_d;
      game_over_q       <= game_over_d;
      winner_valid_q    <= winner_valid_d;
      winner_q          <= winner_d;
      draw_q            <= draw_d;
      move_count_q      <= move_count_d;
    end
  end

  // Outputs come straight from flops; ready is additionally masked by a
  // same-cycle new_game so a simultaneous move is visibly refused
  always_comb begin
    move_ready      = move_ready_q & ~new_game;
    cell_set        = cell_set_q;
    cell_set_symbol = cell_set_symbol_q;
    cell_reset      = cell_reset_q;
    turn            = turn_q;
    move_ack        = move_ack_q;
    move_err        = move_err_q;
    game_over       = game_over_q;
    winner_valid    = winner_valid_q;
    winner          = winner_q;
    draw            = draw_q;
    move_count      = move_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ttt_move_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : tb_ttt_move_ctrl                                      |
// | Brief    : Self-checking bench for ttt_move_ctrl with a board    |
// |            cell model, directed vector table and random games    |
// |            compared against a board-level reference model.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_ttt_move_ctrl;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_WIN  = 2;
  localparam int K_DRAW = 3;
  localparam int K_NONE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_idx;

  logic       move_ready, cell_set_symbol, cell_reset, turn, move_ack, move_err;
  logic       game_over, winner_valid, winner, draw;
  logic [8:0] cell_valid, cell_symbol, cell_set;
  logic [3:0] move_count;

  logic       a_move_ready, a_cell_set_symbol, a_cell_reset, a_turn, a_move_ack, a_move_err;
  logic       a_game_over, a_winner_valid, a_winner, a_draw;
  logic [8:0] a_cell_valid, a_cell_symbol, a_cell_set;
  logic [3:0] a_move_count;

  always #5 clk = ~clk;

  ttt_move_ctrl dut (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_ready(move_ready), .move_idx(move_idx), .cell_valid(cell_valid),
    .cell_symbol(cell_symbol), .cell_set(cell_set), .cell_set_symbol(cell_set_symbol),
    .cell_reset(cell_reset), .turn(turn), .move_ack(move_ack), .move_err(move_err),
    .game_over(game_over), .winner_valid(winner_valid), .winner(winner), .draw(draw),
    .move_count(move_count)
  );

  ttt_move_ctrl #(.FIRST_SYMBOL(1'b0), .ALT_START(1'b1)) dut_alt (
    .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
    .move_ready(a_move_ready), .move_idx(move_idx), .cell_valid(a_cell_valid),
    .cell_symbol(a_cell_symbol), .cell_set(a_cell_set), .cell_set_symbol(a_cell_set_symbol),
    .cell_reset(a_cell_reset), .turn(a_turn), .move_ack(a_move_ack), .move_err(a_move_err),
    .game_over(a_game_over), .winner_valid(a_winner_valid), .winner(a_winner), .draw(a_draw),
    .move_count(a_move_count)
  );

  // Bank of nine board cells for each controller
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cell_valid <= '0; cell_symbol <= '0;
    end else if (cell_reset) begin
      cell_valid <= '0; cell_symbol <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (cell_set[i]) begin cell_valid[i] <= 1'b1; cell_symbol[i] <= cell_set_symbol; end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cell_valid <= '0; a_cell_symbol <= '0;
    end else if (a_cell_reset) begin
      a_cell_valid <= '0; a_cell_symbol <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (a_cell_set[i]) begin a_cell_valid[i] <= 1'b1; a_cell_symbol[i] <= a_cell_set_symbol; end
    end
  end

  // ---------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: board of symbols (-1 = empty)
  // ---------------------------------------------------------------
  int brd[9];
  int m_turn, m_count, m_over, m_winner, ng_count;

  function automatic bit has_line(input int s);
    for (int r = 0; r < 3; r++) begin
      if (brd[3*r] == s && brd[3*r+1] == s && brd[3*r+2] == s) return 1'b1;
      if (brd[r] == s && brd[r+3] == s && brd[r+6] == s) return 1'b1;
    end
    if (brd[0] == s && brd[4] == s && brd[8] == s) return 1'b1;
    if (brd[2] == s && brd[4] == s && brd[6] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) brd[i] = -1;
    m_turn = 0; m_count = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic model_step(input int idx, output int exp);
    bit illegal;
    illegal = (m_over != 0) || (idx > 8);
    if (!illegal) illegal = (brd[idx] != -1);
    if (illegal) begin
      exp = K_ERR;
    end else begin
      brd[idx] = m_turn;
      if (has_line(m_turn)) begin
        exp = K_WIN; m_over = 1; m_winner = m_turn;
      end else begin
        m_count++;
        if (m_count == 9) begin exp = K_DRAW; m_over = 1; end
        else begin exp = K_ACK; m_turn ^= 1; end
      end
    end
  endtask

  // ---------------------------------------------------------------
  // Drive one move and classify what the controller did with it
  // ---------------------------------------------------------------
  task automatic do_move(input int idx, output int obs);
    int ack_n, ack_cyc;
    logic [8:0] exp_set;
    obs = K_NONE; ack_n = 0; ack_cyc = 0;
    @(negedge clk);
    chk("ready_before_move", move_ready, 1);
    move_valid = 1'b1; move_idx = 4'(idx);
    @(negedge clk);
    move_valid = 1'b0;
    if (move_err === 1'b1) begin
      obs = K_ERR;
      chk("err_no_write", cell_set, 0);
      chk("err_no_ack", move_ack, 0);
    end else begin
      exp_set = (idx < 9) ? (9'd1 << idx) : 9'd0;
      chk("cell_set_onehot", cell_set, exp_set);
      chk("cell_set_symbol", cell_set_symbol, m_turn);
      for (int k = 2; k <= 12; k++) begin
        @(negedge clk);
        chk("no_extra_write", cell_set, 0);
        if (move_ack === 1'b1) begin ack_n++; ack_cyc = k; obs = K_ACK; end
        if (game_over === 1'b1 && obs == K_NONE)
          obs = (winner_valid === 1'b1) ? K_WIN : ((draw === 1'b1) ? K_DRAW : K_NONE);
      end
      if (obs == K_ACK) begin
        chk("ack_latency", ack_cyc, 10);
        chk("ack_pulses", ack_n, 1);
      end else begin
        chk("no_ack_on_end", ack_n, 0);
      end
    end
  endtask

  task automatic run_move(input int idx, input int tbl_exp, input int tbl_win, input bit from_tbl);
    int obs, exp, was_over;
    was_over = m_over;
    do_move(idx, obs);
    model_step(idx, exp);
    if (from_tbl) chk("vec_kind", obs, tbl_exp);
    else          chk("rand_kind", obs, exp);
    case (exp)
      K_ACK: begin
        chk("turn_after_ack", turn, m_turn);
        chk("count_after_ack", move_count, m_count);
        chk("not_over", game_over, 0);
      end
      K_ERR: begin
        chk("over_unchanged", game_over, was_over);
        if (was_over == 0) begin
          chk("turn_after_err", turn, m_turn);
          chk("count_after_err", move_count, m_count);
        end
      end
      K_WIN: begin
        chk("win_over", game_over, 1);
        chk("win_valid", winner_valid, 1);
        chk("win_not_draw", draw, 0);
        chk("win_symbol", winner, from_tbl ? tbl_win : m_winner);
      end
      default: begin
        chk("draw_over", game_over, 1);
        chk("draw_flag", draw, 1);
        chk("draw_no_winner", winner_valid, 0);
        chk("draw_count", move_count, 9);
      end
    endcase
  endtask

  // new_game pulse with a simultaneous move request that must be refused
  task automatic new_game_seq();
    @(negedge clk);
    new_game = 1'b1; move_valid = 1'b1; move_idx = 4'd4;
    #1 chk("ng_ready_low", move_ready, 0);
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0; ng_count++;
    chk("ng_cell_reset", cell_reset, 1);
    chk("ng_no_write", cell_set, 0);
    chk("ng_no_err", move_err, 0);
    chk("ng_count", move_count, 0);
    chk("ng_over", game_over, 0);
    chk("ng_flags", {winner_valid, draw, move_ack}, 0);
    chk("ng_turn", turn, 0);
    chk("alt_turn", a_turn, ng_count % 2);
    @(negedge clk);
    chk("ng_ready", move_ready, 1);
    chk("ng_reset_off", cell_reset, 0);
    model_reset();
  endtask

  // new_game arriving while the third move is still being checked
  task automatic abort_seq();
    int ack_seen;
    ack_seen = 0;
    @(negedge clk);
    move_valid = 1'b1; move_idx = 4'd4;
    @(negedge clk);
    move_valid = 1'b0;
    chk("abort_write", cell_set, 9'h010);
    @(negedge clk);
    @(negedge clk);
    new_game = 1'b1;
    #1 chk("abort_ready_low", move_ready, 0);
    @(negedge clk);
    new_game = 1'b0; ng_count++;
    chk("abort_cell_reset", cell_reset, 1);
    chk("abort_count", move_count, 0);
    chk("abort_turn", turn, 0);
    chk("abort_alt_turn", a_turn, ng_count % 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (move_ack === 1'b1) ack_seen++;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_board_clear", cell_valid, 0);
    model_reset();
  endtask

  // ---------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------
  typedef struct {
    int ng;    // pulse new_game before this move
    int idx;
    int exp;
    int win;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int ng, input int idx, input int exp, input int win);
    vec_t v;
    v.ng = ng; v.idx = idx; v.exp = exp; v.win = win;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int free[$];
    reset = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_idx = 4'd0; ng_count = 0;
    model_reset();

    // Game A: X wins on row 0, with illegal moves in between and after
    add(0, 0, K_ACK, 0); add(0, 3, K_ACK, 0); add(0, 1, K_ACK, 0); add(0, 4, K_ACK, 0);
    add(0, 4, K_ERR, 0); add(0, 9, K_ERR, 0); add(0, 2, K_WIN, 0); add(0, 5, K_ERR, 0);
    // Game B: full board without a line
    add(1, 0, K_ACK, 0); add(0, 1, K_ACK, 0); add(0, 2, K_ACK, 0); add(0, 4, K_ACK, 0);
    add(0, 3, K_ACK, 0); add(0, 5, K_ACK, 0); add(0, 7, K_ACK, 0); add(0, 6, K_ACK, 0);
    add(0, 8, K_DRAW, 0); add(0, 0, K_ERR, 0);
    // Game C: O wins on row 1
    add(1, 0, K_ACK, 0); add(0, 3, K_ACK, 0); add(0, 1, K_ACK, 0); add(0, 4, K_ACK, 0);
    add(0, 8, K_ACK, 0); add(0, 5, K_WIN, 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cell_reset", cell_reset, 1);
    chk("rst_ready", move_ready, 0);
    chk("rst_turn", turn, 0);
    chk("rst_count", move_count, 0);
    chk("rst_flags", {move_ack, move_err, game_over, winner_valid, draw}, 0);
    chk("rst_cell_set", cell_set, 0);
    chk("rst_alt_turn", a_turn, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_cell_reset", cell_reset, 1);
    chk("rel_ready_low", move_ready, 0);
    @(negedge clk);
    chk("rel_ready", move_ready, 1);
    chk("rel_reset_off", cell_reset, 0);
    chk("rel_turn", turn, 0);
    chk("rel_count", move_count, 0);

    foreach (vecs[i]) begin
      if (vecs[i].ng != 0) new_game_seq();
      run_move(vecs[i].idx, vecs[i].exp, vecs[i].win, 1'b1);
    end

    // Abort during CHECK of the third move, then the aborted cell is free again
    new_game_seq();
    run_move(0, K_ACK, 0, 1'b1);
    run_move(1, K_ACK, 0, 1'b1);
    abort_seq();
    run_move(4, K_ACK, 0, 1'b1);

    // Random games against the reference model
    for (int g = 0; g < 12; g++) begin
      new_game_seq();
      for (int m = 0; m < 14; m++) begin
        free.delete();
        for (int i = 0; i < 9; i++) if (brd[i] == -1) free.push_back(i);
        if ($urandom_range(0, 3) != 0 && free.size() > 0)
          idx = free[$urandom_range(0, free.size() - 1)];
        else
          idx = $urandom_range(0, 10);
        run_move(idx, 0, 0, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (m_over != 0 && $urandom_range(0, 1) == 0) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
